// File: rtl/bnn_pkg.sv
// Shared constants and state encoding for the binarized network layers.
package bnn_pkg;

  localparam int L2_NCH   = 60;
  localparam int FMAP_DIM = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } pool_state_t;

endpackage

// File: rtl/binpool2x2_ch.sv
// Combinational 2x2 max-pool of one binarized channel; with +1 encoded as 1, max is OR.
module binpool2x2_ch #(
  parameter int DIM = 8
) (
  input  logic [0:DIM*DIM-1]             ch_i,
  output logic [0:(DIM/2)*(DIM/2)-1]     pool_o
);

  localparam int HD = DIM / 2;

  genvar gi;
  generate
    for (gi = 0; gi < HD * HD; gi++) begin : g_pool
      localparam int PR   = gi / HD;
      localparam int PK   = gi % HD;
      localparam int BASE = (2 * PR) * DIM + 2 * PK;
      assign pool_o[gi] = ch_i[BASE] | ch_i[BASE + 1] |
                          ch_i[BASE + DIM] | ch_i[BASE + DIM + 1];
    end
  endgenerate

endmodule

// File: rtl/binpool2_stream.sv
// Captures a binarized feature map, pools every channel 2x2 and streams one pooled channel per beat.
module binpool2_stream
  import bnn_pkg::*;
#(
  parameter int NCH = L2_NCH,
  parameter int DIM = FMAP_DIM
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [0:NCH*DIM*DIM-1]          in_map,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [0:(DIM/2)*(DIM/2)-1]      out_data,
  output logic [$clog2(NCH)-1:0]          out_ch,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last
);

  localparam int MAPW = DIM * DIM;
  localparam int PW   = (DIM / 2) * (DIM / 2);
  localparam int CW   = $clog2(NCH);
  localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);

  pool_state_t     state_q;
  logic [CW-1:0]   ch_q;
  logic [0:PW-1]   pooled     [NCH];
  logic [0:PW-1]   pool_buf_q [NCH];

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      binpool2x2_ch #(.DIM(DIM)) u_pool (
        .ch_i   (in_map[gi*MAPW +: MAPW]),
        .pool_o (pooled[gi])
      );
    end
  endgenerate

  // The buffer is only loaded from IDLE, so a map in flight is never overwritten.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      for (int i = 0; i < NCH; i++) begin
        pool_buf_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < NCH; i++) begin
              pool_buf_q[i] <= pooled[i];
            end
            ch_q    <= '0;
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (ch_q == LAST_CH) begin
              ch_q    <= '0;
              state_q <= IDLE;
            end else begin
              ch_q <= ch_q + CW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == STREAM);
  assign out_ch    = ch_q;
  assign out_data  = pool_buf_q[ch_q];
  assign out_last  = out_valid && (ch_q == LAST_CH);

endmodule

// File: tb/tb_binpool2_stream.sv
// Directed checks of pooling, streaming order, backpressure, input blocking and mid-stream reset.
module tb_binpool2_stream;

  localparam int NCH  = 60;
  localparam int DIM  = 8;
  localparam int MAPW = DIM * DIM;
  localparam int PW   = 16;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [0:NCH*MAPW-1]   in_map;
  logic                  in_valid;
  logic                  in_ready;
  logic [0:PW-1]         out_data;
  logic [5:0]            out_ch;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  int errors = 0;
  int checks = 0;

  binpool2_stream #(.NCH(NCH), .DIM(DIM)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_map    (in_map),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // Channel c carries a single set bit that pools onto pooled bit (c % 16).
  function automatic logic [0:NCH*MAPW-1] pat_map();
    logic [0:NCH*MAPW-1] m;
    int p;
    m = '0;
    for (int c = 0; c < NCH; c++) begin
      p = c % 16;
      m[c*MAPW + (2*(p/4))*DIM + 2*(p%4) + 1] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [0:PW-1] pat_exp(input int c);
    logic [0:PW-1] e;
    e = '0;
    e[c % 16] = 1'b1;
    return e;
  endfunction

  task automatic accept_map(input logic [0:NCH*MAPW-1] m, input string name);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: in_ready=%b required 1", name, in_ready);
    end
    in_map   = m;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    $display("map %s accepted at %0t", name, $time);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_map = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks += 4;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    if (out_ch !== 6'd0) begin errors++; $display("FAIL reset out_ch: got %0d want 0", out_ch); end
    if (out_data !== 16'h0) begin errors++; $display("FAIL reset out_data: got %h want 0000", out_data); end
  endtask

  task automatic test_single_bit();
    logic [0:NCH*MAPW-1] m;
    logic [0:PW-1] e;
    m = '0;
    m[5*MAPW + 3*DIM + 6] = 1'b1;
    out_ready = 1'b1;
    accept_map(m, "single_bit");
    for (int k = 0; k < NCH; k++) begin
      @(negedge clk);
      e = '0;
      if (k == 5) e[7] = 1'b1;
      checks += 4;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL single valid beat %0d: got %b want 1", k, out_valid); end
      if (out_ch !== 6'(k)) begin errors++; $display("FAIL single ch beat %0d: got %0d want %0d", k, out_ch, k); end
      if (out_data !== e) begin errors++; $display("FAIL single data beat %0d: got %h want %h", k, out_data, e); end
      if (out_last !== (k == NCH-1)) begin errors++; $display("FAIL single last beat %0d: got %b want %b", k, out_last, k == NCH-1); end
    end
    @(negedge clk);
    checks += 2;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL single in_ready after: got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL single valid after: got %b want 0", out_valid); end
  endtask

  task automatic test_all_ones();
    logic [0:NCH*MAPW-1] m;
    logic [0:PW-1] e;
    m = '1;
    out_ready = 1'b1;
    accept_map(m, "all_ones");
    for (int k = 0; k < NCH; k++) begin
      @(negedge clk);
      checks += 3;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL ones valid beat %0d: got %b want 1", k, out_valid); end
      if (out_ch !== 6'(k)) begin errors++; $display("FAIL ones ch beat %0d: got %0d want %0d", k, out_ch, k); end
      if (out_data !== 16'hFFFF) begin errors++; $display("FAIL ones data beat %0d: got %h want ffff", k, out_data); end
    end
    // Back-to-back: the next map goes in on the first cycle in_ready is back.
    m = '0;
    m[0] = 1'b1;
    accept_map(m, "back_to_back");
    e = '0;
    e[0] = 1'b1;
    @(negedge clk);
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b valid: got %b want 1", out_valid); end
    if (out_ch !== 6'd0) begin errors++; $display("FAIL b2b ch: got %0d want 0", out_ch); end
    if (out_data !== e) begin errors++; $display("FAIL b2b data: got %h want %h", out_data, e); end
    repeat (NCH) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b drain in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_backpressure();
    int k;
    int cyc;
    logic rdy;
    out_ready = 1'b0;
    accept_map(pat_map(), "backpressure");
    k = 0;
    cyc = 0;
    while (k < NCH && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      checks += 4;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp valid beat %0d: got %b want 1", k, out_valid); end
      if (out_ch !== 6'(k)) begin errors++; $display("FAIL bp ch beat %0d: got %0d want %0d", k, out_ch, k); end
      if (out_data !== pat_exp(k)) begin errors++; $display("FAIL bp data beat %0d: got %h want %h", k, out_data, pat_exp(k)); end
      if (out_last !== (k == NCH-1)) begin errors++; $display("FAIL bp last beat %0d: got %b want %b", k, out_last, k == NCH-1); end
      rdy = ($urandom_range(0, 9) < 3);
      out_ready = rdy;
      if (rdy) k++;
    end
    checks++;
    if (k != NCH) begin errors++; $display("FAIL bp beat count: got %0d want %0d", k, NCH); end
    @(negedge clk);
    out_ready = 1'b0;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp extra beat: out_valid=%b want 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp in_ready after: got %b want 1", in_ready); end
  endtask

  task automatic test_ignore_in_valid();
    out_ready = 1'b0;
    accept_map(pat_map(), "first_map");
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL ignore in_ready: got %b want 0", in_ready); end
    in_map   = '1;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < NCH; k++) begin
      @(negedge clk);
      checks += 2;
      if (out_ch !== 6'(k)) begin errors++; $display("FAIL ignore ch beat %0d: got %0d want %0d", k, out_ch, k); end
      if (out_data !== pat_exp(k)) begin errors++; $display("FAIL ignore data beat %0d: got %h want %h", k, out_data, pat_exp(k)); end
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL ignore in_ready after: got %b want 1", in_ready); end
  endtask

  task automatic test_reset_mid_stream();
    logic [0:NCH*MAPW-1] m;
    logic [0:PW-1] e;
    out_ready = 1'b1;
    accept_map('1, "reset_mid");
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      checks++;
      if (out_ch !== 6'(k)) begin errors++; $display("FAIL rstmid ch beat %0d: got %0d want %0d", k, out_ch, k); end
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid out_valid: got %b want 0", out_valid); end
    if (out_ch !== 6'd0) begin errors++; $display("FAIL rstmid out_ch: got %0d want 0", out_ch); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid in_ready: got %b want 1", in_ready); end
    if (out_data !== 16'h0) begin errors++; $display("FAIL rstmid out_data: got %h want 0000", out_data); end
    m = '0;
    m[5*MAPW + 3*DIM + 6] = 1'b1;
    accept_map(m, "after_reset");
    for (int k = 0; k < NCH; k++) begin
      @(negedge clk);
      e = '0;
      if (k == 5) e[7] = 1'b1;
      checks += 2;
      if (out_ch !== 6'(k)) begin errors++; $display("FAIL postrst ch beat %0d: got %0d want %0d", k, out_ch, k); end
      if (out_data !== e) begin errors++; $display("FAIL postrst data beat %0d: got %h want %h", k, out_data, e); end
    end
  endtask

  initial begin
    test_reset();
    test_single_bit();
    test_all_ones();
    test_backpressure();
    test_ignore_in_valid();
    test_reset_mid_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
